// File: rtl/traffic_light_pkg.sv
// Shared lamp codes, phase encoding and FSM state type for the traffic light
// monitor and the matching generator.
package traffic_light_pkg;

   // One-hot lamp codes as seen on lights[2:0] = {Red, Yellow, Green}
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_RED    = 3'b100;

   typedef enum logic [1:0] {
      PH_GREEN   = 2'b00,
      PH_YELLOW  = 2'b01,
      PH_RED     = 2'b10,
      PH_UNKNOWN = 2'b11
   } phase_e;

   typedef enum logic {
      ST_SYNC  = 1'b0,
      ST_TRACK = 1'b1
   } state_e;

   // The only phase that may legally follow p
   function automatic phase_e next_phase(input phase_e p);
      case (p)
         PH_GREEN:  return PH_YELLOW;
         PH_YELLOW: return PH_RED;
         PH_RED:    return PH_GREEN;
         default:   return PH_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational one-hot check and lamp-code to phase decode.
module traffic_light_decode
   import traffic_light_pkg::*;
(
   input  logic [2:0] code_i,
   output logic       valid_o,
   output phase_e     phase_o
);

   // 000 and multi-hot codes are invalid and decode to PH_UNKNOWN
   always_comb begin
      valid_o = 1'b1;
      phase_o = PH_UNKNOWN;
      case (code_i)
         LIGHT_GREEN:  phase_o = PH_GREEN;
         LIGHT_YELLOW: phase_o = PH_YELLOW;
         LIGHT_RED:    phase_o = PH_RED;
         default:      valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor: locks onto a valid lamp code, then checks
// order (G->Y->R->G), minimum/maximum dwell per phase, and counts full cycles.
// Expects MAX_DWELL >= MIN_DWELL >= 1.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       lights,
   input  logic             err_clr,
   output logic [1:0]       phase,
   output logic             locked,
   output logic             err_code,
   output logic             err_seq,
   output logic             err_dwell,
   output logic             err_sticky,
   output logic [CNT_W-1:0] cycle_count
);

   // Dwell must be able to hold MAX_DWELL+1, the value that flags overstay
   localparam int DW_W = $clog2(MAX_DWELL + 2);
   localparam logic [DW_W-1:0] DW_MIN  = DW_W'(MIN_DWELL);
   localparam logic [DW_W-1:0] DW_OVER = DW_W'(MAX_DWELL + 1);
   localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);

   logic   code_valid;
   phase_e code_phase;

   state_e           state_q,     state_d;
   phase_e           phase_q,     phase_d;
   logic [DW_W-1:0]  dwell_q,     dwell_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic             err_code_q,  err_code_d;
   logic             err_seq_q,   err_seq_d;
   logic             err_dwell_q, err_dwell_d;
   logic             sticky_q,    sticky_d;
   logic [DW_W-1:0]  dwell_inc;

   traffic_light_decode u_decode (
      .code_i  (lights),
      .valid_o (code_valid),
      .phase_o (code_phase)
   );

   assign dwell_inc = dwell_q + DW_ONE;

   // Next-state: each branch raises at most one error pulse; any error drops to SYNC
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      dwell_d     = dwell_q;
      count_d     = count_q;
      err_code_d  = 1'b0;
      err_seq_d   = 1'b0;
      err_dwell_d = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (code_valid) begin
               state_d = ST_TRACK;
               phase_d = code_phase;
               dwell_d = DW_ONE;
            end else begin
               phase_d = PH_UNKNOWN;
               dwell_d = '0;
            end
         end
         default: begin
            if (!code_valid) begin
               err_code_d = 1'b1;
            end else if (code_phase == phase_q) begin
               // Dwell saturates at MAX_DWELL+1; reaching it is the overstay
               dwell_d = dwell_inc;
               if (dwell_inc == DW_OVER) err_dwell_d = 1'b1;
            end else if (code_phase == next_phase(phase_q) && dwell_q >= DW_MIN) begin
               phase_d = code_phase;
               dwell_d = DW_ONE;
               if (phase_q == PH_RED) count_d = count_q + 1'b1;
            end else begin
               err_seq_d = 1'b1;
            end
            if (err_code_d || err_seq_d || err_dwell_d) begin
               state_d = ST_SYNC;
               phase_d = PH_UNKNOWN;
            end
         end
      endcase
      // A new error wins over a simultaneous clear
      if (err_code_d || err_seq_d || err_dwell_d) sticky_d = 1'b1;
      else if (err_clr)                           sticky_d = 1'b0;
      else                                        sticky_d = sticky_q;
   end

   // State and registered outputs, synchronous reset overriding everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SYNC;
         phase_q     <= PH_UNKNOWN;
         dwell_q     <= '0;
         count_q     <= '0;
         err_code_q  <= 1'b0;
         err_seq_q   <= 1'b0;
         err_dwell_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         dwell_q     <= dwell_d;
         count_q     <= count_d;
         err_code_q  <= err_code_d;
         err_seq_q   <= err_seq_d;
         err_dwell_q <= err_dwell_d;
         sticky_q    <= sticky_d;
      end
   end

   assign phase       = phase_q;
   assign locked      = (state_q == ST_TRACK);
   assign err_code    = err_code_q;
   assign err_seq     = err_seq_q;
   assign err_dwell   = err_dwell_q;
   assign err_sticky  = sticky_q;
   assign cycle_count = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus a randomized run,
// two instances (MIN=1/MAX=4 and MIN=2/MAX=3) checked against a rule-level model.
module tb_traffic_light_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] lights = 3'b000;
   logic       err_clr = 1'b0;

   logic [1:0] ph1, ph2;
   logic       lk1, lk2, ec1, ec2, es1, es2, ed1, ed2, st1, st2;
   logic [7:0] cnt1, cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(4), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .lights(lights), .err_clr(err_clr),
      .phase(ph1), .locked(lk1), .err_code(ec1), .err_seq(es1),
      .err_dwell(ed1), .err_sticky(st1), .cycle_count(cnt1));

   traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) dut2 (
      .clk(clk), .reset(reset), .lights(lights), .err_clr(err_clr),
      .phase(ph2), .locked(lk2), .err_code(ec2), .err_seq(es2),
      .err_dwell(ed2), .err_sticky(st2), .cycle_count(cnt2));

   wire [14:0] got1 = {ph1, lk1, ec1, es1, ed1, st1, cnt1};
   wire [14:0] got2 = {ph2, lk2, ec2, es2, ed2, st2, cnt2};
   localparam logic [14:0] RST_VEC = {2'b11, 5'b00000, 8'd0};

   // Rule-level model: phases numbered 0=G,1=Y,2=R; the legal successor is (p+1)%3
   typedef struct {
      bit locked;
      int ph;
      int dwell;
      int cnt;
      bit ec, es, ed, sticky;
   } mstate_t;

   mstate_t m1, m2;

   function automatic mstate_t model(input mstate_t s, input logic [2:0] l,
                                     input bit clr, input bit rst, input int mn, input int mx);
      mstate_t n = s;
      int p;
      if (rst) begin
         n.locked = 0; n.ph = 3; n.dwell = 0; n.cnt = 0;
         n.ec = 0; n.es = 0; n.ed = 0; n.sticky = 0;
         return n;
      end
      n.ec = 0; n.es = 0; n.ed = 0;
      p = (l == 3'b001) ? 0 : (l == 3'b010) ? 1 : (l == 3'b100) ? 2 : -1;
      if (!s.locked) begin
         if (p >= 0) begin n.locked = 1; n.ph = p; n.dwell = 1; end
         else n.ph = 3;
      end else if (p < 0) begin
         n.ec = 1;
      end else if (p == s.ph) begin
         n.dwell = s.dwell + 1;
         if (n.dwell > mx) n.ed = 1;
      end else if (p == (s.ph + 1) % 3 && s.dwell >= mn) begin
         if (s.ph == 2) n.cnt = (s.cnt + 1) % 256;
         n.ph = p; n.dwell = 1;
      end else begin
         n.es = 1;
      end
      if (n.ec || n.es || n.ed) begin n.locked = 0; n.ph = 3; n.dwell = 0; end
      if (n.ec || n.es || n.ed) n.sticky = 1;
      else if (clr) n.sticky = 0;
      return n;
   endfunction

   function automatic logic [14:0] vec(input mstate_t s);
      return {s.ph[1:0], s.locked, s.ec, s.es, s.ed, s.sticky, s.cnt[7:0]};
   endfunction

   // Drive one sample, wait for the edge, advance both models
   task automatic step(input logic [2:0] l, input bit c, input bit r);
      lights = l; err_clr = c; reset = r;
      @(posedge clk); #1;
      m1 = model(m1, l, c, r, 1, 4);
      m2 = model(m2, l, c, r, 2, 3);
   endtask

   task automatic test_reset;
      step(3'($urandom), 1'b0, 1'b1);
      step(3'($urandom), 1'b1, 1'b1);
      checks++; if (got1 !== RST_VEC) begin errors++; $display("FAIL reset_dut1 got=%h exp=%h", got1, RST_VEC); end
      checks++; if (got2 !== RST_VEC) begin errors++; $display("FAIL reset_dut2 got=%h exp=%h", got2, RST_VEC); end
   endtask

   task automatic test_cycle;
      logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
      step(3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(seq[i], 1'b0, 1'b0);
         checks++; if (got1 !== vec(m1)) begin errors++; $display("FAIL cycle_dut1[%0d] got=%h exp=%h", i, got1, vec(m1)); end
         checks++; if ({lk1, ec1, es1, ed1} !== 4'b1000) begin errors++; $display("FAIL cycle_lock[%0d] got=%b exp=1000", i, {lk1, ec1, es1, ed1}); end
      end
      checks++; if (cnt1 !== 8'd1) begin errors++; $display("FAIL cycle_count got=%0d exp=1", cnt1); end
   endtask

   task automatic test_seq_err;
      step(3'b000, 1'b0, 1'b1);
      step(3'b001, 1'b0, 1'b0);
      step(3'b100, 1'b0, 1'b0);
      checks++; if ({es1, ec1, ed1, lk1, ph1, st1} !== 7'b1000111) begin errors++; $display("FAIL seq_err got=%b exp=1000111", {es1, ec1, ed1, lk1, ph1, st1}); end
      checks++; if (got2 !== vec(m2)) begin errors++; $display("FAIL seq_err_dut2 got=%h exp=%h", got2, vec(m2)); end
      step(3'b000, 1'b0, 1'b0);
      checks++; if ({es1, st1} !== 2'b01) begin errors++; $display("FAIL seq_err_pulse got=%b exp=01", {es1, st1}); end
   endtask

   task automatic test_code_err;
      step(3'b000, 1'b0, 1'b1);
      step(3'b010, 1'b0, 1'b0);
      step(3'b011, 1'b0, 1'b0);
      checks++; if ({ec1, es1, ed1, lk1, ph1} !== 6'b100011) begin errors++; $display("FAIL code_err got=%b exp=100011", {ec1, es1, ed1, lk1, ph1}); end
      step(3'b001, 1'b0, 1'b0);
      checks++; if ({ec1, lk1, ph1} !== 4'b0100) begin errors++; $display("FAIL code_relock got=%b exp=0100", {ec1, lk1, ph1}); end
      checks++; if (got2 !== vec(m2)) begin errors++; $display("FAIL code_err_dut2 got=%h exp=%h", got2, vec(m2)); end
   endtask

   task automatic test_dwell;
      step(3'b000, 1'b0, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         step(3'b010, 1'b0, 1'b0);
         checks++; if ({ed1, lk1} !== ((i == 5) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL dwell1[%0d] got=%b", i, {ed1, lk1}); end
         checks++; if (got2 !== vec(m2)) begin errors++; $display("FAIL dwell2[%0d] got=%h exp=%h", i, got2, vec(m2)); end
      end
      checks++; if (ph1 !== 2'b01) begin errors++; $display("FAIL dwell_relock_phase got=%b exp=01", ph1); end
   endtask

   task automatic test_early_change;
      step(3'b000, 1'b0, 1'b1);
      step(3'b001, 1'b0, 1'b0);
      step(3'b010, 1'b0, 1'b0);
      checks++; if ({es1, lk1, es2, lk2} !== 4'b0110) begin errors++; $display("FAIL early_change got=%b exp=0110", {es1, lk1, es2, lk2}); end
      step(3'b010, 1'b0, 1'b0);
      step(3'b010, 1'b0, 1'b0);
      step(3'b100, 1'b0, 1'b0);
      checks++; if ({es2, lk2, ph2} !== 4'b0110) begin errors++; $display("FAIL min_dwell_ok got=%b exp=0110", {es2, lk2, ph2}); end
      checks++; if (got1 !== vec(m1)) begin errors++; $display("FAIL early_dut1 got=%h exp=%h", got1, vec(m1)); end
   endtask

   task automatic test_wrap;
      step(3'b000, 1'b0, 1'b1);
      step(3'b001, 1'b0, 1'b0);
      for (int i = 0; i < 255; i++) begin
         step(3'b010, 1'b0, 1'b0);
         step(3'b100, 1'b0, 1'b0);
         step(3'b001, 1'b0, 1'b0);
      end
      checks++; if (cnt1 !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", cnt1); end
      step(3'b010, 1'b0, 1'b0);
      step(3'b100, 1'b0, 1'b0);
      step(3'b001, 1'b0, 1'b0);
      checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL wrap_0 got=%0d exp=0", cnt1); end
      checks++; if (got2 !== vec(m2)) begin errors++; $display("FAIL wrap_dut2 got=%h exp=%h", got2, vec(m2)); end
      step(3'b010, 1'b0, 1'b0);
      step(3'b100, 1'b0, 1'b1);
      checks++; if (got1 !== RST_VEC) begin errors++; $display("FAIL mid_reset got=%h exp=%h", got1, RST_VEC); end
   endtask

   task automatic test_err_clr;
      step(3'b000, 1'b0, 1'b1);
      step(3'b001, 1'b0, 1'b0);
      step(3'b100, 1'b0, 1'b0);
      step(3'b001, 1'b1, 1'b0);
      checks++; if ({st1, lk1} !== 2'b01) begin errors++; $display("FAIL clr_no_err got=%b exp=01", {st1, lk1}); end
      step(3'b100, 1'b1, 1'b0);
      checks++; if ({st1, es1} !== 2'b11) begin errors++; $display("FAIL clr_with_err got=%b exp=11", {st1, es1}); end
      checks++; if (got2 !== vec(m2)) begin errors++; $display("FAIL clr_dut2 got=%h exp=%h", got2, vec(m2)); end
   endtask

   task automatic test_random;
      logic [2:0] l = 3'b001;
      int r;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 85 && r >= 45 && $onehot(l)) l = {l[1:0], l[2]};
         else if (r >= 85) l = 3'($urandom);
         step(l, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 2));
         checks++; if (got1 !== vec(m1)) begin errors++; $display("FAIL random_dut1[%0d] got=%h exp=%h", i, got1, vec(m1)); end
         checks++; if (got2 !== vec(m2)) begin errors++; $display("FAIL random_dut2[%0d] got=%h exp=%h", i, got2, vec(m2)); end
      end
   endtask

   initial begin
      test_reset();
      test_cycle();
      test_seq_err();
      test_code_err();
      test_dwell();
      test_early_change();
      test_wrap();
      test_err_clr();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
